// File: rtl/r5fp_div_if.sv
// Handshake bundle between the FP divide sequencer and the external integer divider.
interface r5fp_div_if #(
  parameter int XW = 26
);
  logic [XW-1:0] idiv_N;
  logic [XW-1:0] idiv_D;
  logic          idiv_strobe;
  logic [XW-1:0] idiv_Quo;
  logic [XW-1:0] idiv_Rem;
  logic          idiv_done;
  logic          idiv_ready;

  modport master (
    output idiv_N, idiv_D, idiv_strobe,
    input  idiv_Quo, idiv_Rem, idiv_done, idiv_ready
  );

  modport slave (
    input  idiv_N, idiv_D, idiv_strobe,
    output idiv_Quo, idiv_Rem, idiv_done, idiv_ready
  );
endinterface

// File: rtl/r5fp_div.sv
// R5FP extended-format divide: special operands resolved on a fast path, otherwise the
// quotient comes from an external integer divider and is normalised for the shared rounder.
module r5fp_div #(
  parameter int SIG_W = 23,
  parameter int EXP_W = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SIG_W+EXP_W:0] a_i,
  input  logic [SIG_W+EXP_W:0] b_i,
  input  logic [2:0]           rnd_i,
  input  logic                 strobe_i,
  output logic [EXP_W-1:0]     xExp_o,
  output logic [SIG_W+2:0]     xSig_o,
  output logic [4:0]           xMidStatus_o,
  output logic [7:0]           xStatus_fast_o,
  output logic [SIG_W+EXP_W:0] x_fast_o,
  output logic                 x_use_fast,
  output logic [2:0]           rnd_o,
  output logic                 done_o,
  output logic                 ready_o,
  r5fp_div_if.master           idiv
);
  localparam int W   = SIG_W + EXP_W + 1;
  localparam int XW  = (SIG_W % 2 == 1) ? SIG_W + 3 : SIG_W + 4;
  localparam int PAD = XW - SIG_W - 1;
  localparam int EW  = EXP_W + 2;
  localparam logic signed [EW-1:0] BIAS    = EW'(2**(EXP_W-1) - 1);
  localparam logic signed [EW-1:0] EXP_MAX = EW'(2**EXP_W - 2);
  localparam logic signed [EW-1:0] EXP_ONE = EW'(1);
  localparam logic [XW-1:0] LOW_MASK = XW'((64'd1 << (XW - SIG_W - 2)) - 64'd1);
  localparam logic [W-1:0]  QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(SIG_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_FAST, S_ISSUE, S_WAIT, S_FIN} state_t;
  state_t state, state_nxt;

  logic                 a_s, b_s, sign;
  logic [EXP_W-1:0]     a_e, b_e;
  logic [SIG_W-1:0]     a_f, b_f;
  logic                 a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, special;
  logic [W-1:0]         fast_x;
  logic [7:0]           fast_st;
  logic signed [EW-1:0] exp_r, e_fin;
  logic                 q_top, sticky;
  logic [XW-1:0]        q_norm;
  logic [SIG_W+1:0]     mant;
  logic [SIG_W:0]       sig_r;
  logic                 round_bit, sticky_bit, use_fast_r;

  assign {a_s, a_e, a_f} = a_i;
  assign {b_s, b_e, b_f} = b_i;
  assign sign    = a_s ^ b_s;
  assign a_nan   = (&a_e) & (|a_f);
  assign b_nan   = (&b_e) & (|b_f);
  assign a_inf   = (&a_e) & ~(|a_f);
  assign b_inf   = (&b_e) & ~(|b_f);
  assign a_zero  = ~(|a_e);
  assign b_zero  = ~(|b_e);
  assign special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

  // Priority order matters: NaN beats 0/0 and Inf/Inf, which beat the signed results.
  always_comb begin
    fast_x  = {sign, {EXP_W{1'b1}}, {SIG_W{1'b0}}};
    fast_st = 8'd0;
    if (a_nan | b_nan) begin
      fast_x     = QNAN;
      fast_st[2] = (a_nan & ~a_f[SIG_W-1]) | (b_nan & ~b_f[SIG_W-1]);
    end else if ((a_zero & b_zero) | (a_inf & b_inf)) begin
      fast_x     = QNAN;
      fast_st[2] = 1'b1;
    end else if (a_inf) begin
      fast_st[1] = 1'b1;
    end else if (b_zero) begin
      fast_st[7] = 1'b1;
    end else if (a_zero | b_inf) begin
      fast_x     = {sign, {(W-1){1'b0}}};
      fast_st[0] = 1'b1;
    end
  end

  // Quotient lies in (0.5, 2); a clear MSB means one extra left shift and exponent - 1.
  assign q_top  = idiv.idiv_Quo[XW-1];
  assign q_norm = q_top ? idiv.idiv_Quo : idiv.idiv_Quo << 1;
  assign mant   = q_norm[XW-1 -: SIG_W+2];
  assign sticky = (|(q_norm & LOW_MASK)) | (|idiv.idiv_Rem);
  assign e_fin  = exp_r - $signed({{(EW-1){1'b0}}, ~q_top});

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (strobe_i) state_nxt = special ? S_FAST : S_ISSUE;
      S_FAST:  state_nxt = S_IDLE;
      S_ISSUE: if (idiv.idiv_ready) state_nxt = S_WAIT;
      S_WAIT:  if (idiv.idiv_done) state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign idiv.idiv_strobe = (state == S_ISSUE) && idiv.idiv_ready;
  assign done_o           = (state == S_FAST) || (state == S_FIN);
  assign ready_o          = !reset && (state == S_IDLE);
  assign xSig_o           = {sig_r, round_bit, sticky_bit};
  assign x_use_fast       = use_fast_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      xExp_o         <= '0;
      sig_r          <= '0;
      round_bit      <= 1'b0;
      sticky_bit     <= 1'b0;
      xMidStatus_o   <= '0;
      xStatus_fast_o <= '0;
      x_fast_o       <= '0;
      use_fast_r     <= 1'b0;
      rnd_o          <= '0;
      exp_r          <= '0;
      idiv.idiv_N    <= '0;
      idiv.idiv_D    <= '0;
    end else begin
      if (state == S_IDLE && strobe_i) begin
        rnd_o          <= rnd_i;
        use_fast_r     <= special;
        x_fast_o       <= fast_x;
        xStatus_fast_o <= fast_st;
        xMidStatus_o   <= {sign, 4'b0000};
        exp_r          <= $signed({2'b00, a_e}) - $signed({2'b00, b_e}) + BIAS;
        if (!special) begin
          idiv.idiv_N <= {1'b1, a_f, {PAD{1'b0}}};
          idiv.idiv_D <= {1'b1, b_f, {PAD{1'b0}}};
        end
      end
      if (state == S_WAIT && idiv.idiv_done) begin
        if (e_fin < EXP_ONE) begin
          xExp_o     <= EXP_W'(1);
          sig_r      <= {1'b1, {SIG_W{1'b0}}};
          round_bit  <= 1'b0;
          sticky_bit <= 1'b1;
        end else if (e_fin > EXP_MAX) begin
          xExp_o     <= EXP_MAX[EXP_W-1:0];
          sig_r      <= '1;
          round_bit  <= 1'b1;
          sticky_bit <= 1'b1;
        end else begin
          xExp_o     <= e_fin[EXP_W-1:0];
          sig_r      <= mant[SIG_W+1:1];
          round_bit  <= mant[0];
          sticky_bit <= sticky;
        end
      end
    end
  end
endmodule

// File: tb/tb_r5fp_div.sv
// Bench for r5fp_div: behavioural integer divider plus an arithmetic reference model.
module tb_r5fp_div;
  localparam int SIG_W = 23;
  localparam int EXP_W = 9;
  localparam int XW    = 26;
  localparam int W     = 33;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] a_i = '0, b_i = '0;
  logic [2:0]   rnd_i = '0;
  logic         strobe_i = 1'b0;
  logic [EXP_W-1:0] xExp_o;
  logic [SIG_W+2:0] xSig_o;
  logic [4:0]   xMidStatus_o;
  logic [7:0]   xStatus_fast_o;
  logic [W-1:0] x_fast_o;
  logic         x_use_fast, done_o, ready_o;
  logic [2:0]   rnd_o;

  int total = 0;
  int bad   = 0;

  r5fp_div_if #(.XW(XW)) idiv_bus();

  r5fp_div #(.SIG_W(SIG_W), .EXP_W(EXP_W)) dut (
    .clk(clk), .reset(reset), .a_i(a_i), .b_i(b_i), .rnd_i(rnd_i), .strobe_i(strobe_i),
    .xExp_o(xExp_o), .xSig_o(xSig_o), .xMidStatus_o(xMidStatus_o),
    .xStatus_fast_o(xStatus_fast_o), .x_fast_o(x_fast_o), .x_use_fast(x_use_fast),
    .rnd_o(rnd_o), .done_o(done_o), .ready_o(ready_o), .idiv(idiv_bus)
  );

  always #5 clk = ~clk;

  // Integer divider stand-in: variable latency, optional forced-busy.
  int            div_cnt = 0;
  int            div_lat = 0;
  int            stb_cnt = 0;
  logic          hold_busy = 1'b0;
  logic [XW-1:0] n_l, d_l;

  assign idiv_bus.idiv_ready = (div_cnt == 0) && !hold_busy;

  always @(posedge clk) begin
    idiv_bus.idiv_done <= 1'b0;
    if (idiv_bus.idiv_strobe === 1'b1) stb_cnt <= stb_cnt + 1;
    if (div_cnt > 0) begin
      div_cnt <= div_cnt - 1;
      if (div_cnt == 1) begin
        idiv_bus.idiv_done <= 1'b1;
        idiv_bus.idiv_Quo  <= XW'((64'(n_l) << (XW-1)) / 64'(d_l));
        idiv_bus.idiv_Rem  <= XW'((64'(n_l) << (XW-1)) % 64'(d_l));
      end
    end else if (idiv_bus.idiv_strobe === 1'b1 && idiv_bus.idiv_ready) begin
      n_l     <= idiv_bus.idiv_N;
      d_l     <= idiv_bus.idiv_D;
      div_cnt <= (div_lat > 0) ? div_lat : int'($urandom_range(1, 5));
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ext(input logic [31:0] f);
    logic [8:0] e;
    if (f[30:23] == 8'd0)        e = 9'd0;
    else if (f[30:23] == 8'hFF)  e = 9'h1FF;
    else                         e = {1'b0, f[30:23]} + 9'd128;
    return {f[31], e, f[22:0]};
  endfunction

  // Reference for the special-operand table.
  task automatic model_fast(input logic [W-1:0] a, input logic [W-1:0] b,
                            output logic sp, output logic [W-1:0] x, output logic [7:0] st);
    logic an, bn, ai, bi, az, bz, s;
    an = (a[31:23] == 9'h1FF) && (a[22:0] != 0);
    bn = (b[31:23] == 9'h1FF) && (b[22:0] != 0);
    ai = (a[31:23] == 9'h1FF) && (a[22:0] == 0);
    bi = (b[31:23] == 9'h1FF) && (b[22:0] == 0);
    az = (a[31:23] == 0);
    bz = (b[31:23] == 0);
    s  = a[32] ^ b[32];
    sp = an | bn | ai | bi | az | bz;
    st = 8'h00;
    x  = {s, 9'h1FF, 23'd0};
    if (an || bn) begin
      x = 33'h0FFC00000;
      if ((an && !a[22]) || (bn && !b[22])) st = 8'h04;
    end else if ((az && bz) || (ai && bi)) begin
      x = 33'h0FFC00000; st = 8'h04;
    end else if (ai) st = 8'h02;
    else if (bz) st = 8'h80;
    else if (az || bi) begin x = {s, 32'd0}; st = 8'h01; end
  endtask

  // Reference for the normal path: exact ratio of significands at a wider scale.
  task automatic model_norm(input logic [W-1:0] a, input logic [W-1:0] b,
                            output logic [8:0] xe, output logic [25:0] xs);
    logic [63:0] ma, mb, q, r, mant;
    logic        st;
    int          e;
    ma = {40'd0, 1'b1, a[22:0]};
    mb = {40'd0, 1'b1, b[22:0]};
    q  = (ma << 26) / mb;
    r  = (ma << 26) % mb;
    e  = int'(a[31:23]) - int'(b[31:23]) + 255;
    if (q >= (64'd1 << 26)) begin
      mant = q >> 2; st = (q[1:0] != 0) || (r != 0);
    end else begin
      mant = q >> 1; st = q[0] || (r != 0); e = e - 1;
    end
    if (e < 1) begin
      xe = 9'd1; xs = {1'b1, 24'd0, 1'b1};
    end else if (e > 510) begin
      xe = 9'd510; xs = '1;
    end else begin
      xe = 9'(e); xs = {mant[24:0], st};
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] rnd, input int busy);
    logic         sp;
    logic [W-1:0] fx;
    logic [7:0]   fst;
    logic [8:0]   xe;
    logic [25:0]  xs;
    int           lat, s0;
    model_fast(a, b, sp, fx, fst);
    model_norm(a, b, xe, xs);
    @(negedge clk);
    chk("ready_before", ready_o, 1);
    a_i = a; b_i = b; rnd_i = rnd; strobe_i = 1'b1;
    hold_busy = (busy > 0) && !sp;
    s0 = stb_cnt;
    @(negedge clk);
    a_i = W'($urandom); b_i = W'($urandom); rnd_i = 3'($urandom);
    lat = 1;
    if (hold_busy) begin
      repeat (busy) @(negedge clk);
      lat += busy;
      chk("issue_hold", {stb_cnt - s0, 31'd0, done_o}, 64'd0);
      hold_busy = 1'b0;
    end
    while (!done_o && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    strobe_i = 1'b0;
    chk("done_seen", done_o, 1);
    chk("use_fast", x_use_fast, sp);
    chk("rnd_latched", rnd_o, rnd);
    if (sp) begin
      chk("fast_latency", lat, 1);
      chk("x_fast", x_fast_o, fx);
      chk("status_fast", xStatus_fast_o, fst);
    end else begin
      chk("x_exp", xExp_o, xe);
      chk("x_sig", xSig_o, xs);
      chk("mid_status", xMidStatus_o, {a[32] ^ b[32], 4'b0000});
      chk("one_idiv_strobe", stb_cnt - s0, 1);
    end
    @(negedge clk);
    chk("done_once", done_o, 0);
  endtask

  initial begin
    int seen;
    logic [W-1:0] ra, rb;
    repeat (3) @(negedge clk);
    chk("ready_in_reset", ready_o, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_ready", ready_o, 1);
    chk("reset_done", done_o, 0);
    chk("reset_outs", {xExp_o, xSig_o, x_use_fast, xStatus_fast_o}, 64'd0);
    chk("reset_idiv", {idiv_bus.idiv_N, idiv_bus.idiv_strobe}, 64'd0);

    run_op(ext(32'h40C00000), ext(32'h40000000), 3'd0, 0);
    chk("six_by_two_exp", xExp_o, 9'd256);
    chk("six_by_two_sig", xSig_o, 26'h3000000);
    run_op(ext(32'h3F800000), ext(32'h40400000), 3'd0, 0);
    run_op(ext(32'h3F800000), ext(32'h40400000), 3'd1, 0);
    run_op(ext(32'h3F800000), ext(32'h00000000), 3'd0, 0);
    chk("div_by_zero_x", x_fast_o, 33'h0FF800000);
    chk("div_by_zero_st", xStatus_fast_o, 8'h80);
    run_op(ext(32'h00000000), ext(32'h80000000), 3'd0, 0);
    chk("zero_by_zero_st", xStatus_fast_o, 8'h04);
    run_op(ext(32'h7F800001), ext(32'h3F800000), 3'd0, 0);
    chk("snan_x", x_fast_o, 33'h0FFC00000);
    run_op(ext(32'h7F7FFFFF), ext(32'h3F000000), 3'd0, 0);
    run_op(ext(32'h7F7FFFFF), ext(32'h3F000000), 3'd1, 0);
    run_op({1'b0, 9'd106, 23'd0}, ext(32'h40000000), 3'd0, 0);
    run_op(ext(32'h3FC00000), ext(32'hBF800000), 3'd2, 4);
    run_op({1'b0, 9'd1, 23'h123456}, {1'b0, 9'd510, 23'h7FFFFF}, 3'd0, 0);
    chk("underflow_clamp_exp", xExp_o, 9'd1);
    run_op({1'b1, 9'd510, 23'h0}, {1'b0, 9'd1, 23'h400000}, 3'd3, 0);
    chk("overflow_clamp_sig", xSig_o, 26'h3FFFFFF);

    // Abort during WAIT: the divider still completes later and must be ignored.
    div_lat = 30;
    @(negedge clk);
    a_i = ext(32'h40400000); b_i = ext(32'h3F800000); strobe_i = 1'b1;
    @(negedge clk);
    strobe_i = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("ready_during_abort", ready_o, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_abort", ready_o, 1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o) seen++;
    end
    chk("no_done_after_abort", seen, 0);
    chk("ready_after_late_done", ready_o, 1);
    div_lat = 0;
    run_op(ext(32'h40400000), ext(32'h3F800000), 3'd0, 0);

    for (int i = 0; i < 150; i++) begin
      for (int k = 0; k < 2; k++) begin
        int c;
        logic [8:0]  e;
        logic [22:0] f;
        c = $urandom_range(0, 11);
        f = 23'($urandom);
        case (c)
          0: begin e = 9'd0; f = '0; end
          1: begin e = 9'h1FF; f = '0; end
          2: begin e = 9'h1FF; f[22] = 1'b1; end
          3: begin e = 9'h1FF; f[22] = 1'b0; if (f == 0) f = 23'd1; end
          4, 5: e = ($urandom_range(0, 1) == 1) ? 9'($urandom_range(1, 4)) : 9'($urandom_range(506, 510));
          default: e = 9'($urandom_range(1, 510));
        endcase
        if (k == 0) ra = {1'($urandom), e, f};
        else        rb = {1'($urandom), e, f};
      end
      run_op(ra, rb, 3'($urandom_range(0, 4)), ($urandom_range(0, 3) == 0) ? 2 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
